// File: rtl/llc_input_scheduler.sv
// Input scheduler for the LLC pipeline: arbitrates responses, resumed requests,
// a set-by-set flush sweep and round-robin CPU/DMA requests into one datapath.
module llc_input_scheduler #(
  parameter int SET_W    = 9,
  parameter int NUM_SETS = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             dma_valid,
  output logic             dma_ready,
  input  logic             req_stall,
  input  logic             dma_stall,
  input  logic             resume_valid,
  input  logic             flush_req,
  input  logic             proc_done,
  output logic             proc_start,
  output logic [2:0]       sel,
  output logic [SET_W-1:0] flush_set,
  output logic             flush_done,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a source is consumed in the single cycle its ready is high. The
  // grant is decided from the valids seen in IDLE; on the next edge ready,
  // proc_start and sel are registered together, so ready is a one-cycle pulse
  // that is never asserted outside the launch cycle of an operation.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    FLUSH_BUSY = 2'd2
  } state_t;

  localparam logic [2:0] SEL_NONE   = 3'd0;
  localparam logic [2:0] SEL_RSP    = 3'd1;
  localparam logic [2:0] SEL_RESUME = 3'd2;
  localparam logic [2:0] SEL_FLUSH  = 3'd3;
  localparam logic [2:0] SEL_REQ    = 3'd4;
  localparam logic [2:0] SEL_DMA    = 3'd5;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  state_t           r_state;
  logic [2:0]       r_sel;
  logic             r_proc_start;
  logic             r_rsp_ready;
  logic             r_req_ready;
  logic             r_dma_ready;
  logic             r_flush_done;
  logic             r_busy;
  logic [SET_W-1:0] r_flush_set;
  logic             r_flush_active;
  logic             r_rr_ptr;  // 0: req preferred next, 1: dma preferred next

  logic             w_req_elig;
  logic             w_dma_elig;
  logic [2:0]       w_grant;

  // A running sweep holds off CPU and DMA traffic until flush_done.
  assign w_req_elig = req_valid && !req_stall && !r_flush_active;
  assign w_dma_elig = dma_valid && !dma_stall && !r_flush_active;

  always_comb begin
    w_grant = SEL_NONE;
    if (rsp_valid) begin
      w_grant = SEL_RSP;
    end else if (resume_valid) begin
      w_grant = SEL_RESUME;
    end else if (flush_req || r_flush_active) begin
      w_grant = SEL_FLUSH;
    end else if (w_req_elig && w_dma_elig) begin
      w_grant = r_rr_ptr ? SEL_DMA : SEL_REQ;
    end else if (w_req_elig) begin
      w_grant = SEL_REQ;
    end else if (w_dma_elig) begin
      w_grant = SEL_DMA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_sel          <= SEL_NONE;
      r_proc_start   <= 1'b0;
      r_rsp_ready    <= 1'b0;
      r_req_ready    <= 1'b0;
      r_dma_ready    <= 1'b0;
      r_flush_done   <= 1'b0;
      r_busy         <= 1'b0;
      r_flush_set    <= '0;
      r_flush_active <= 1'b0;
      r_rr_ptr       <= 1'b0;
    end else begin
      r_proc_start <= 1'b0;
      r_rsp_ready  <= 1'b0;
      r_req_ready  <= 1'b0;
      r_dma_ready  <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant != SEL_NONE) begin
            r_sel        <= w_grant;
            r_proc_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= BUSY;
            case (w_grant)
              SEL_RSP: r_rsp_ready <= 1'b1;
              SEL_FLUSH: begin
                r_flush_active <= 1'b1;
                r_state        <= FLUSH_BUSY;
              end
              SEL_REQ: begin
                r_req_ready <= 1'b1;
                r_rr_ptr    <= 1'b1;
              end
              SEL_DMA: begin
                r_dma_ready <= 1'b1;
                r_rr_ptr    <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (proc_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sel   <= SEL_NONE;
          end
        end
        FLUSH_BUSY: begin
          if (proc_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sel   <= SEL_NONE;
            if (r_flush_set == LAST_SET) begin
              r_flush_done   <= 1'b1;
              r_flush_set    <= '0;
              r_flush_active <= 1'b0;
            end else begin
              r_flush_set <= r_flush_set + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_sel   <= SEL_NONE;
        end
      endcase
    end
  end

  assign rsp_ready   = r_rsp_ready;
  assign req_ready   = r_req_ready;
  assign dma_ready   = r_dma_ready;
  assign proc_start  = r_proc_start;
  assign sel         = r_sel;
  assign flush_set   = r_flush_set;
  assign flush_done  = r_flush_done;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_llc_input_scheduler.sv
// Directed bench for llc_input_scheduler with a 4-set sweep; expected values
// are hand-derived from the scheduling rules.
module tb_llc_input_scheduler;

  localparam int SET_W    = 2;
  localparam int NUM_SETS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             rsp_valid, req_valid, dma_valid;
  logic             req_stall, dma_stall, resume_valid, flush_req, proc_done;
  logic             rsp_ready, req_ready, dma_ready, proc_start, flush_done, busy;
  logic [2:0]       sel;
  logic [SET_W-1:0] flush_set;
  logic [1:0]       o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  llc_input_scheduler #(.SET_W(SET_W), .NUM_SETS(NUM_SETS)) dut (
    .clk          (clk),
    .rst          (rst),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .req_stall    (req_stall),
    .dma_stall    (dma_stall),
    .resume_valid (resume_valid),
    .flush_req    (flush_req),
    .proc_done    (proc_done),
    .proc_start   (proc_start),
    .sel          (sel),
    .flush_set    (flush_set),
    .flush_done   (flush_done),
    .busy         (busy),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One normal operation: grant edge, optional busy hold cycles, done edge.
  task automatic run_op(input logic [2:0] exp_sel, input int hold, input bit drop);
    tick();
    chk("grant_sel", sel, exp_sel);
    chk("grant_start", proc_start, 1);
    chk("grant_busy", busy, 1);
    chk("grant_rsp_ready", rsp_ready, exp_sel == 3'd1);
    chk("grant_req_ready", req_ready, exp_sel == 3'd4);
    chk("grant_dma_ready", dma_ready, exp_sel == 3'd5);
    if (drop) begin
      case (exp_sel)
        3'd1: rsp_valid = 1'b0;
        3'd2: resume_valid = 1'b0;
        3'd4: req_valid = 1'b0;
        3'd5: dma_valid = 1'b0;
        default: ;
      endcase
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_sel", sel, exp_sel);
      chk("hold_busy", busy, 1);
      chk("hold_start", proc_start, 0);
      chk("hold_readies", {rsp_ready, req_ready, dma_ready}, 0);
    end
    proc_done = 1'b1;
    tick();
    chk("done_busy", busy, 0);
    chk("done_sel", sel, 0);
    chk("done_start", proc_start, 0);
    proc_done = 1'b0;
  endtask

  // One flush set: grant edge then done edge; checks the sweep advance.
  task automatic flush_op(input int set, input bit last);
    tick();
    chk("fl_sel", sel, 3);
    chk("fl_set", flush_set, set);
    chk("fl_start", proc_start, 1);
    chk("fl_state", o_dbg_state, 2);
    chk("fl_readies", {rsp_ready, req_ready, dma_ready}, 0);
    flush_req = 1'b0;
    proc_done = 1'b1;
    tick();
    chk("fl_done_busy", busy, 0);
    chk("fl_done_pulse", flush_done, last);
    chk("fl_next_set", flush_set, last ? 0 : set + 1);
    proc_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rsp_valid = 0; req_valid = 0; dma_valid = 0;
    req_stall = 0; dma_stall = 0; resume_valid = 0;
    flush_req = 0; proc_done = 0;
    tick();
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", proc_start, 0);
    chk("rst_readies", {rsp_ready, req_ready, dma_ready}, 0);
    chk("rst_flush", {flush_done, flush_set}, 0);
    chk("rst_state", o_dbg_state, 0);
    rst = 1'b0;
    tick();

    // rsp beats req and dma
    rsp_valid = 1; req_valid = 1; dma_valid = 1;
    run_op(3'd1, 1, 1);

    // req/dma alternate round-robin, starting at req
    run_op(3'd4, 0, 0);
    run_op(3'd5, 0, 0);
    run_op(3'd4, 0, 0);
    run_op(3'd5, 0, 0);
    req_valid = 0; dma_valid = 0;

    // stalled req is held off until the stall drops
    req_stall = 1; req_valid = 1;
    tick();
    chk("stall_start", proc_start, 0);
    chk("stall_ready", req_ready, 0);
    tick();
    chk("stall_busy", busy, 0);
    chk("stall_ready2", req_ready, 0);
    req_stall = 0;
    run_op(3'd4, 2, 1);

    // proc_done in IDLE has no effect
    proc_done = 1;
    tick();
    chk("idle_done_busy", busy, 0);
    chk("idle_done_set", flush_set, 0);
    chk("idle_done_pulse", flush_done, 0);
    proc_done = 0;

    // single flush_req pulse sweeps all sets
    flush_req = 1;
    flush_op(0, 0);
    flush_op(1, 0);
    flush_op(2, 0);
    flush_op(3, 1);
    tick();
    chk("sweep_end_pulse", flush_done, 0);
    chk("sweep_end_busy", busy, 0);
    chk("sweep_end_set", flush_set, 0);

    // rsp and resume interleave; pending req waits for flush_done
    req_valid = 1; flush_req = 1;
    flush_op(0, 0);
    flush_op(1, 0);
    rsp_valid = 1;
    run_op(3'd1, 0, 1);
    chk("inter_set_rsp", flush_set, 2);
    flush_op(2, 0);
    resume_valid = 1;
    run_op(3'd2, 0, 1);
    chk("inter_set_resume", flush_set, 3);
    flush_op(3, 1);
    run_op(3'd4, 0, 1);

    // reset mid-sweep abandons it; next flush restarts at set 0
    flush_req = 1;
    flush_op(0, 0);
    flush_op(1, 0);
    flush_op(2, 0);
    tick();
    chk("pre_rst_sel", sel, 3);
    chk("pre_rst_set", flush_set, 3);
    rst = 1'b1;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", proc_start, 0);
    chk("arst_readies", {rsp_ready, req_ready, dma_ready}, 0);
    chk("arst_flush", {flush_done, flush_set}, 0);
    tick();
    rst = 1'b0;
    flush_req = 1;
    tick();
    chk("restart_sel", sel, 3);
    chk("restart_set", flush_set, 0);
    chk("restart_start", proc_start, 1);
    flush_req = 0;
    proc_done = 1;
    tick();
    chk("restart_next_set", flush_set, 1);
    proc_done = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/llc_input_scheduler.md
LLC_INPUT_SCHEDULER -- requirements
Module: llc_input_scheduler

Interface
REQ-001 SHALL have parameter SET_W, default 9, meaning the LLC set index width.
REQ-002 SHALL have parameter NUM_SETS, default 512, meaning the number of sets swept by a flush (at most 2^SET_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rsp_valid, input, 1 bit: a coherence response is pending.
REQ-006 SHALL have port rsp_ready, output, 1 bit: the response is consumed this cycle.
REQ-007 SHALL have port req_valid, input, 1 bit: a CPU request is pending.
REQ-008 SHALL have port req_ready, output, 1 bit: the CPU request is consumed this cycle.
REQ-009 SHALL have port dma_valid, input, 1 bit: a DMA request is pending.
REQ-010 SHALL have port dma_ready, output, 1 bit: the DMA request is consumed this cycle.
REQ-011 SHALL have port req_stall, input, 1 bit: new CPU requests are blocked.
REQ-012 SHALL have port dma_stall, input, 1 bit: new DMA requests are blocked (DMA or recall pending).
REQ-013 SHALL have port resume_valid, input, 1 bit: a stalled request can now be resumed.
REQ-014 SHALL have port flush_req, input, 1 bit: level request to flush all sets.
REQ-015 SHALL have port proc_done, input, 1 bit: the datapath has finished the current operation.
REQ-016 SHALL have port proc_start, output, 1 bit: one-cycle pulse that launches an operation.
REQ-017 SHALL have port sel, output, 3 bits: operation source (0 none, 1 rsp, 2 resume, 3 flush, 4 req, 5 dma).
REQ-018 SHALL have port flush_set, output, SET_W bits: the set being flushed.
REQ-019 SHALL have port flush_done, output, 1 bit: one-cycle pulse when a flush sweep completes.
REQ-020 SHALL have port busy, output, 1 bit: an operation is in flight.

Function
REQ-021 SHALL implement three states:
- IDLE: no operation in flight.
- BUSY: a normal operation is in flight.
- FLUSH_BUSY: a flush operation for one set is in flight.
REQ-022 SHALL decide the grant in IDLE and, on the next edge, register sel, pulse proc_start, and assert the matching ready for exactly that one cycle; ready and proc_start SHALL never be asserted outside that cycle.
REQ-023 SHALL grant in this priority order: rsp_valid, then resume_valid, then flush (flush_req or flush active), then req/dma.
- req is eligible only when req_stall=0.
- dma is eligible only when dma_stall=0.
REQ-024 SHALL arbitrate req and dma round-robin with a 1-bit pointer.
- The pointer is updated only on a req or dma grant and then points to the other source.
- When only one of the two is eligible, that one is granted.
REQ-025 SHALL hold sel constant and busy=1 in BUSY and FLUSH_BUSY.
REQ-026 SHALL return to IDLE from BUSY or FLUSH_BUSY on the edge at which proc_done=1, and SHALL then set busy=0 and sel=0.
- The next grant can occur no earlier than the following edge (minimum two cycles per operation).
REQ-027 SHALL ignore proc_done while in IDLE.
REQ-028 SHALL, on a flush grant, set a flush-active flag and issue sel=3 with the current flush_set (first set = 0).
REQ-029 SHALL advance the sweep on proc_done in FLUSH_BUSY:
- If flush_set = NUM_SETS-1: pulse flush_done for one cycle, clear flush_set to 0 and clear the flush-active flag.
- Otherwise: increment flush_set and leave the flush-active flag set.
REQ-030 SHALL, while the flush-active flag is set, let rsp and resume interleave between flush sets and block req and dma until flush_done.
REQ-031 SHALL ignore deassertion of flush_req while the flush-active flag is set (the sweep always completes).
REQ-032 SHALL keep flush_set stable when rsp or resume operations interleave.
REQ-033 SHALL wrap flush_set modulo NUM_SETS and never leave it at or above NUM_SETS.

Reset
REQ-034 SHALL, while rst=1, force: state=IDLE, sel=0, busy=0, proc_start=0, all ready outputs=0, flush_done=0, flush_set=0, flush-active flag=0, round-robin pointer=req.
REQ-035 SHALL abandon any in-flight operation or flush sweep on reset; a later flush restarts at set 0.

Verification
REQ-036 SHALL be checked with this scenario: rsp_valid, req_valid and dma_valid all 1 in IDLE -> next cycle rsp_ready=1, sel=1, proc_start=1, while req_ready=0 and dma_ready=0.
REQ-037 SHALL be checked with this scenario: req_valid and dma_valid held at 1, proc_done returned each operation -> grants alternate req, dma, req, dma (sel 4,5,4,5).
REQ-038 SHALL be checked with this scenario: req_stall=1 with only req_valid=1 -> no grant; release req_stall -> req_ready pulses one cycle later.
REQ-039 SHALL be checked with this scenario: NUM_SETS=4, flush_req pulsed once, proc_done returned each op -> flush_set 0,1,2,3 issued, then a single flush_done pulse, then flush_set=0.
REQ-040 SHALL be checked with this scenario: during the sweep, rsp_valid at set 2 -> rsp is granted between sets with flush_set still 2, and a pending req is granted only after flush_done.
REQ-041 SHALL be checked with this scenario: rst asserted in FLUSH_BUSY at set 3 -> all outputs at reset values; a new flush starts at set 0.
